// File: rtl/esc_pwm_generator.sv
// ESC PWM generator: turns a rate-limited motor value into a servo-style
// pulse train. Width is latched once per frame at t=0 so mid-frame input
// changes never reshape the pulse in flight. A timeout drops the output to
// the minimum pulse if value updates stop arriving.
module esc_pwm_generator #(
  parameter int unsigned VALUE_WIDTH    = 8,
  parameter int unsigned PERIOD_US      = 2500,
  parameter int unsigned MIN_PULSE_US   = 1000,
  parameter int unsigned MAX_PULSE_US   = 2000,
  parameter int unsigned SCALE_US       = 4,
  parameter int unsigned TIMEOUT_FRAMES = 4
) (
  input  logic                   us_clk,
  input  logic                   resetn,
  input  logic [VALUE_WIDTH-1:0] value_in,
  input  logic                   value_valid,
  input  logic                   arm_in,
  output logic                   pwm_out,
  output logic                   complete_signal,
  output logic                   active_signal,
  output logic                   failsafe_signal,
  output logic [15:0]            pulse_width_us
);

  localparam int unsigned CNT_W = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_FRAMES + 1) > 0 ? $clog2(TIMEOUT_FRAMES + 1) : 1;

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_HIGH  = 2'd1,
    S_LOW   = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  state_t                 w_start_state;
  logic [CNT_W-1:0]       r_t;
  logic [CNT_W-1:0]       w_t_next;
  logic [VALUE_WIDTH-1:0] r_shadow;
  logic [TO_W-1:0]        r_to_cnt;
  logic [TO_W-1:0]        w_to_next;
  logic                   r_seen;
  logic                   w_seen;
  logic                   r_pwm;
  logic                   r_complete;
  logic                   r_failsafe;
  logic                   w_fs_next;
  logic [15:0]            r_width;
  logic [15:0]            w_width_calc;
  logic [31:0]            w_scaled;
  logic                   w_frame_end;
  logic                   w_frame_start;
  logic                   w_high_end;
  logic                   w_pwm_d;
  logic                   w_complete_d;

  // Frame boundaries and the end of the high phase
  always_comb begin
    w_frame_end   = (r_state != S_START) && (r_t == CNT_W'(PERIOD_US - 1));
    w_frame_start = (r_state == S_START) || w_frame_end;
    w_high_end    = (r_state == S_HIGH) && ((32'(r_t) + 32'd1) == 32'(r_width));
  end

  // Timeout bookkeeping; a strobe on the frame-end cycle still counts for that frame
  always_comb begin
    w_seen    = r_seen | value_valid;
    w_to_next = r_to_cnt;
    w_fs_next = r_failsafe;
    if (w_frame_end) begin
      if (w_seen) begin
        w_to_next = '0;
      end else if (r_to_cnt != TO_W'(TIMEOUT_FRAMES)) begin
        w_to_next = r_to_cnt + TO_W'(1);
      end
    end
    if (value_valid) begin
      w_fs_next = 1'b0;
    end else if (w_frame_end && !w_seen && (w_to_next == TO_W'(TIMEOUT_FRAMES))) begin
      w_fs_next = 1'b1;
    end
  end

  // Width for the frame about to start; failsafe uses the value it takes on this edge
  always_comb begin
    w_scaled = 32'(MIN_PULSE_US) + 32'(r_shadow) * 32'(SCALE_US);
    if (!arm_in || w_fs_next) begin
      w_width_calc = 16'(MIN_PULSE_US);
    end else if (w_scaled > 32'(MAX_PULSE_US)) begin
      w_width_calc = 16'(MAX_PULSE_US);
    end else begin
      w_width_calc = 16'(w_scaled);
    end
    w_start_state = (w_width_calc == 16'd0) ? S_LOW : S_HIGH;
  end

  // State register
  always_ff @(posedge us_clk) begin
    if (!resetn) begin
      r_state <= S_START;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_START: w_state_next = w_start_state;
      S_HIGH:  if (w_high_end) w_state_next = S_LOW;
      S_LOW:   if (w_frame_end) w_state_next = w_start_state;
      default: w_state_next = S_START;
    endcase
  end

  // Output decode for the next cycle
  always_comb begin
    w_t_next     = w_frame_start ? '0 : r_t + CNT_W'(1);
    w_pwm_d      = (w_state_next == S_HIGH);
    w_complete_d = (w_state_next != S_START) && (w_t_next == CNT_W'(PERIOD_US - 1));
  end

  // Datapath and registered outputs
  always_ff @(posedge us_clk) begin
    if (!resetn) begin
      r_t        <= '0;
      r_shadow   <= '0;
      r_to_cnt   <= '0;
      r_seen     <= 1'b0;
      r_pwm      <= 1'b0;
      r_complete <= 1'b0;
      r_failsafe <= 1'b0;
      r_width    <= 16'(MIN_PULSE_US);
    end else begin
      r_t        <= w_t_next;
      r_to_cnt   <= w_to_next;
      r_seen     <= w_frame_end ? 1'b0 : w_seen;
      r_pwm      <= w_pwm_d;
      r_complete <= w_complete_d;
      r_failsafe <= w_fs_next;
      if (value_valid) begin
        r_shadow <= value_in;
      end
      if (w_frame_start) begin
        r_width <= w_width_calc;
      end
    end
  end

  assign pwm_out         = r_pwm;
  assign active_signal   = r_pwm;
  assign complete_signal = r_complete;
  assign failsafe_signal = r_failsafe;
  assign pulse_width_us  = r_width;

endmodule
